ob_drain: RTL and testbench



---
 rtl/ob_drain.sv | 212 +++++++++++++++++++++
 tb/tb_ob_drain.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ob_drain.sv
// Output-buffer drain: reads a window of COL-lane rows from the output buffer and
// streams them one lane per beat. Define OB_DRAIN_CHECKSUM_EN to add checksum_o.
module ob_drain #(
   parameter int WIDTH  = 8,
   parameter int COL    = 4,
   parameter int O_SIZE = 256
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        start_i,
   input  logic [$clog2(O_SIZE)-1:0]   base_addr_i,
   input  logic [$clog2(O_SIZE):0]     num_rows_i,
   output logic                        mem_cenb_o,
   output logic                        mem_wenb_o,
   output logic [$clog2(O_SIZE)-1:0]   mem_addr_o,
   input  logic [COL*WIDTH-1:0]        mem_q_i,
   output logic [WIDTH-1:0]            out_data_o,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic                        out_last_o,
   output logic                        busy_o,
   output logic                        done_o
`ifdef OB_DRAIN_CHECKSUM_EN
   ,
   output logic [15:0]                 checksum_o
`endif
);

   localparam int AW = $clog2(O_SIZE);
   localparam int NW = AW + 1;
   localparam int LW = $clog2(COL);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
   typedef logic [COL-1:0][WIDTH-1:0] row_t;

   state_t          st_q, st_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [AW-1:0]   maddr_q, maddr_d;
   logic [NW-1:0]   num_q, num_d;
   logic [NW-1:0]   iss_q, iss_d;
   // [0]: read presented to memory this cycle, [1]: its data is on mem_q_i
   logic [1:0]      vld_pipe_q, vld_pipe_d;
   logic [1:0]      lst_pipe_q, lst_pipe_d;
   row_t            sr_q, sr_d;
   logic            sr_vld_q, sr_vld_d;
   logic            sr_lst_q, sr_lst_d;
   logic [LW-1:0]   lane_q, lane_d;
   row_t            pf_q, pf_d;
   logic            pf_vld_q, pf_vld_d;
   logic            pf_lst_q, pf_lst_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
`ifdef OB_DRAIN_CHECKSUM_EN
   logic [15:0]     chk_q, chk_d;
`endif

   logic hs, lane_end, sr_free;

   assign hs       = sr_vld_q && out_ready_i;
   assign lane_end = hs && (lane_q == LW'(COL-1));
   assign sr_free  = !sr_vld_q || lane_end;

   function automatic logic [AW-1:0] nxt_addr(input logic [AW-1:0] a);
      return (a == AW'(O_SIZE-1)) ? '0 : a + AW'(1);
   endfunction

   always_comb begin
      st_d       = st_q;
      addr_d     = addr_q;
      maddr_d    = maddr_q;
      num_d      = num_q;
      iss_d      = iss_q;
      vld_pipe_d = {vld_pipe_q[0], 1'b0};
      lst_pipe_d = {lst_pipe_q[0], 1'b0};
      sr_d       = sr_q;
      sr_vld_d   = sr_vld_q;
      sr_lst_d   = sr_lst_q;
      lane_d     = lane_q;
      pf_d       = pf_q;
      pf_vld_d   = pf_vld_q;
      pf_lst_d   = pf_lst_q;
`ifdef OB_DRAIN_CHECKSUM_EN
      chk_d      = chk_q;
`endif

      if (hs) begin
         sr_d   = sr_q >> WIDTH;
         lane_d = lane_q + LW'(1);
`ifdef OB_DRAIN_CHECKSUM_EN
         chk_d  = chk_q + 16'(sr_q[0]);
`endif
      end
      if (lane_end) begin
         sr_vld_d = 1'b0;
         lane_d   = '0;
      end

      // Prefetched row wins over returning data; the two are never both present.
      if (sr_free && pf_vld_q) begin
         sr_d     = pf_q;
         sr_vld_d = 1'b1;
         sr_lst_d = pf_lst_q;
         lane_d   = '0;
         pf_vld_d = 1'b0;
      end else if (sr_free && vld_pipe_q[1]) begin
         sr_d     = mem_q_i;
         sr_vld_d = 1'b1;
         sr_lst_d = lst_pipe_q[1];
         lane_d   = '0;
      end
      if (vld_pipe_q[1] && (pf_vld_q || !sr_free)) begin
         pf_d     = mem_q_i;
         pf_vld_d = 1'b1;
         pf_lst_d = lst_pipe_q[1];
      end

      case (st_q)
         IDLE: begin
            if (start_i) begin
               num_d = num_rows_i;
               iss_d = '0;
`ifdef OB_DRAIN_CHECKSUM_EN
               chk_d = '0;
`endif
               if (num_rows_i == '0) begin
                  st_d = FINISH;
               end else begin
                  st_d          = RUN;
                  vld_pipe_d[0] = 1'b1;
                  lst_pipe_d[0] = (num_rows_i == NW'(1));
                  maddr_d       = base_addr_i;
                  addr_d        = nxt_addr(base_addr_i);
                  iss_d         = NW'(1);
               end
            end
         end
         RUN: begin
            // Issue only if the row can land without overflowing the prefetch slot.
            if ((iss_q < num_q) && !vld_pipe_q[0] && !pf_vld_d) begin
               vld_pipe_d[0] = 1'b1;
               lst_pipe_d[0] = ((iss_q + NW'(1)) == num_q);
               maddr_d       = addr_q;
               addr_d        = nxt_addr(addr_q);
               iss_d         = iss_q + NW'(1);
            end
            if (lane_end && sr_lst_q) st_d = FINISH;
         end
         FINISH:  st_d = IDLE;
         default: st_d = IDLE;
      endcase

      busy_d = (st_d != IDLE);
      done_d = (st_q == FINISH);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q       <= IDLE;
         addr_q     <= '0;
         maddr_q    <= '0;
         num_q      <= '0;
         iss_q      <= '0;
         vld_pipe_q <= '0;
         lst_pipe_q <= '0;
         sr_q       <= '0;
         sr_vld_q   <= 1'b0;
         sr_lst_q   <= 1'b0;
         lane_q     <= '0;
         pf_q       <= '0;
         pf_vld_q   <= 1'b0;
         pf_lst_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef OB_DRAIN_CHECKSUM_EN
         chk_q      <= '0;
`endif
      end else begin
         st_q       <= st_d;
         addr_q     <= addr_d;
         maddr_q    <= maddr_d;
         num_q      <= num_d;
         iss_q      <= iss_d;
         vld_pipe_q <= vld_pipe_d;
         lst_pipe_q <= lst_pipe_d;
         sr_q       <= sr_d;
         sr_vld_q   <= sr_vld_d;
         sr_lst_q   <= sr_lst_d;
         lane_q     <= lane_d;
         pf_q       <= pf_d;
         pf_vld_q   <= pf_vld_d;
         pf_lst_q   <= pf_lst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef OB_DRAIN_CHECKSUM_EN
         chk_q      <= chk_d;
`endif
      end
   end

   assign mem_cenb_o  = ~vld_pipe_q[0];
   assign mem_wenb_o  = 1'b1;
   assign mem_addr_o  = maddr_q;
   assign out_data_o  = sr_q[0];
   assign out_valid_o = sr_vld_q;
   assign out_last_o  = sr_vld_q && (lane_q == LW'(COL-1)) && sr_lst_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
`ifdef OB_DRAIN_CHECKSUM_EN
   assign checksum_o  = chk_q;
`endif

endmodule

// File: tb/tb_ob_drain.sv
// Directed bench for ob_drain: drives a behavioural single-port buffer and checks
// beat order, latency, backpressure, wrap, zero rows, abort and start-while-busy.
module tb_ob_drain;
   localparam int WIDTH  = 8;
   localparam int COL    = 4;
   localparam int O_SIZE = 256;
   localparam int AW     = 8;

   logic             clk;
   logic             rst_i;
   logic             start_i;
   logic [AW-1:0]    base_addr_i;
   logic [AW:0]      num_rows_i;
   logic             mem_cenb_o;
   logic             mem_wenb_o;
   logic [AW-1:0]    mem_addr_o;
   logic [31:0]      mem_q;
   logic [WIDTH-1:0] out_data_o;
   logic             out_valid_o;
   logic             out_ready_i;
   logic             out_last_o;
   logic             busy_o;
   logic             done_o;
`ifdef OB_DRAIN_CHECKSUM_EN
   logic [15:0]      checksum_o;
`endif

   logic [31:0] mem [O_SIZE];
   int n_tests = 0;
   int n_fail  = 0;

   ob_drain #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .num_rows_i  (num_rows_i),
      .mem_cenb_o  (mem_cenb_o),
      .mem_wenb_o  (mem_wenb_o),
      .mem_addr_o  (mem_addr_o),
      .mem_q_i     (mem_q),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_last_o  (out_last_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
`ifdef OB_DRAIN_CHECKSUM_EN
      ,
      .checksum_o  (checksum_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (!mem_cenb_o) mem_q <= mem[mem_addr_o];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full drain; mode 0 = ready always high, mode 1 = ready pattern 1,0,0.
   // At iteration poke a conflicting start is pulsed (-1 = never).
   task automatic drain(input int base, input int num, input int mode, input int poke,
                        input string tag);
      int nb, nrd, last_it;
      bit done_seen, stalled, prev_lo;
      logic [7:0]  held, expb;
      logic [15:0] sum;
      logic [31:0] row;
      nb = 0; nrd = 0; last_it = -1; done_seen = 0; stalled = 0; prev_lo = 0;
      held = '0; sum = '0;
      start_i = 1'b1; base_addr_i = AW'(base); num_rows_i = (AW+1)'(num);
      @(posedge clk); #1;
      start_i = 1'b0;
      chk({tag, ":busy_after_start"}, 32'(busy_o), 32'd1);
      for (int it = 0; it < 200 && !done_seen; it++) begin
         out_ready_i = (mode == 0) ? 1'b1 : ((it % 3) == 0);
         if (it == poke) begin
            start_i = 1'b1; base_addr_i = 8'd100; num_rows_i = 9'd3;
         end else begin
            start_i = 1'b0;
         end
         if (!mem_cenb_o) begin
            chk({tag, ":rd_addr"}, 32'(mem_addr_o), 32'((base + nrd) % O_SIZE));
            chk({tag, ":one_outstanding"}, 32'(prev_lo), 32'd0);
            nrd++;
         end
         prev_lo = !mem_cenb_o;
         if (stalled) chk({tag, ":valid_hold"}, 32'(out_valid_o), 32'd1);
         if (out_valid_o) begin
            if (stalled) chk({tag, ":data_hold"}, 32'(out_data_o), 32'(held));
            row  = mem[(base + nb / COL) % O_SIZE];
            expb = row[8*(nb % COL) +: 8];
            if (out_ready_i) begin
               chk({tag, ":beat"}, 32'(out_data_o), 32'(expb));
               chk({tag, ":last"}, 32'(out_last_o), 32'(nb == num*COL - 1));
               if (mode == 0 && nb == 0) chk({tag, ":first_lat"}, 32'(it), 32'd2);
               if (mode == 0 && nb > 0)  chk({tag, ":no_bubble"}, 32'(it - last_it), 32'd1);
               sum = sum + 16'(expb);
               nb++;
               last_it = it;
               stalled = 0;
            end else begin
               stalled = 1;
               held    = out_data_o;
            end
         end else begin
            chk({tag, ":last_idle"}, 32'(out_last_o), 32'd0);
         end
         if (done_o) begin
            done_seen = 1;
            chk({tag, ":done_lat"}, 32'(it - last_it), 32'd2);
            chk({tag, ":busy_at_done"}, 32'(busy_o), 32'd0);
         end
         @(posedge clk); #1;
      end
      start_i = 1'b0;
      chk({tag, ":done_seen"}, 32'(done_seen), 32'd1);
      chk({tag, ":done_pulse"}, 32'(done_o), 32'd0);
      chk({tag, ":beats"}, 32'(nb), 32'(num * COL));
      chk({tag, ":reads"}, 32'(nrd), 32'(num));
      chk({tag, ":idle_after"}, 32'(busy_o), 32'd0);
`ifdef OB_DRAIN_CHECKSUM_EN
      chk({tag, ":checksum"}, 32'(checksum_o), 32'(sum));
`endif
   endtask

   initial begin
      int nb;
      for (int i = 0; i < O_SIZE; i++) mem[i] = '0;
      mem[0]   = 32'h04030201;
      mem[1]   = 32'h08070605;
      mem[2]   = 32'h0c0b0a09;
      mem[3]   = 32'h100f0e0d;
      mem[255] = 32'hf4f3f2f1;
      mem_q = '0;
      rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_rows_i = '0; out_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst:cenb",  32'(mem_cenb_o),  32'd1);
      chk("rst:wenb",  32'(mem_wenb_o),  32'd1);
      chk("rst:addr",  32'(mem_addr_o),  32'd0);
      chk("rst:valid", 32'(out_valid_o), 32'd0);
      chk("rst:data",  32'(out_data_o),  32'd0);
      chk("rst:last",  32'(out_last_o),  32'd0);
      chk("rst:busy",  32'(busy_o),      32'd0);
      chk("rst:done",  32'(done_o),      32'd0);
`ifdef OB_DRAIN_CHECKSUM_EN
      chk("rst:checksum", 32'(checksum_o), 32'd0);
`endif
      rst_i = 1'b0;
      @(posedge clk); #1;

      drain(0, 2, 0, -1, "basic");
`ifdef OB_DRAIN_CHECKSUM_EN
      chk("basic:checksum_const", 32'(checksum_o), 32'h0024);
`endif
      drain(0, 2, 1, -1, "bp");
      drain(0, 4, 1, -1, "bp4");
      drain(255, 2, 0, -1, "wrap");
      drain(0, 0, 0, -1, "zero");
      drain(0, 2, 0, 4, "busy_start");

      // Abort after the third handshaken beat of a 4-row drain.
      start_i = 1'b1; base_addr_i = '0; num_rows_i = 9'd4; out_ready_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      nb = 0;
      for (int it = 0; it < 20 && nb < 3; it++) begin
         if (out_valid_o) nb++;
         if (nb == 3) rst_i = 1'b1;
         @(posedge clk); #1;
      end
      chk("abort:beats_before", 32'(nb), 32'd3);
      chk("abort:cenb",  32'(mem_cenb_o),  32'd1);
      chk("abort:addr",  32'(mem_addr_o),  32'd0);
      chk("abort:valid", 32'(out_valid_o), 32'd0);
      chk("abort:data",  32'(out_data_o),  32'd0);
      chk("abort:last",  32'(out_last_o),  32'd0);
      chk("abort:busy",  32'(busy_o),      32'd0);
      chk("abort:done",  32'(done_o),      32'd0);
      rst_i = 1'b0;
      for (int it = 0; it < 4; it++) begin
         @(posedge clk); #1;
         chk("abort:no_done",  32'(done_o),      32'd0);
         chk("abort:no_valid", 32'(out_valid_o), 32'd0);
         chk("abort:no_read",  32'(mem_cenb_o),  32'd1);
      end
      drain(0, 1, 0, -1, "restart");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
